sddr_read_leveler: RTL and testbench

Per-byte-lane read-capture calibration engine for the DDR PHY. After a start pulse it sweeps each lane's DQS input delay over its full tap range, issues test reads through the controller and compares the captured rise/fall bytes with a known pattern. It then loads each lane's delay with the centre of its first passing window. It sits between the controller's init sequencer and the PHY's variable input-delay elements, and generalises the PHY's fixed single-delay DQS path to N lanes with closed-loop tap selection.

---
 rtl/sddr_read_leveler.sv | 165 ++++++++++++++++
 tb/tb_sddr_read_leveler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sddr_read_leveler.sv
// rtl/sddr_read_leveler.sv - per-lane DQS read-capture tap sweep and window centring.
// Optional read-timeout abort guarded by SDDR_RDLVL_TIMEOUT_EN.
module sddr_read_leveler #(
  parameter int         DATA_BITS      = 16,
  parameter int         TAP_BITS       = 5,
  parameter int         SETTLE_CYCLES  = 8,
  parameter int         SAMPLES        = 4,
  parameter logic [7:0] PAT_RISE       = 8'h55,
  parameter logic [7:0] PAT_FALL       = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                             in_ddr_clock_i,
  input  logic                             in_phy_reset_i,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             fail_o,
  output logic                             rd_req_o,
  input  logic                             rd_ack_i,
  input  logic                             rd_valid_i,
  input  logic [2*DATA_BITS-1:0]           rd_dq_i,
  output logic [DATA_BITS/8-1:0]           dly_ld_o,
  output logic [(DATA_BITS/8)*TAP_BITS-1:0] dly_val_o,
  output logic [DATA_BITS/8-1:0]           dly_ce_o,
  output logic                             dly_inc_o,
  output logic [(DATA_BITS/8)*TAP_BITS-1:0] tap_o,
  output logic [DATA_BITS/8-1:0]           lane_fail_o
);
  localparam int L       = DATA_BITS / 8;
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SMP_W   = $clog2(SAMPLES + 1);

  typedef enum logic [3:0] {IDLE, LOAD0, SETTLE, REQ, WAIT, EVAL, STEP, CENTER, FINISH} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]             cnt_q;
  logic [SMP_W-1:0]             smp_q;
  logic [TAP_BITS-1:0]          tap_q;
  logic [L-1:0]                 pass_q, seen_q, closed_q, lane_fail_q, match;
  logic [L-1:0][TAP_BITS-1:0]   first_q, last_q, center_val, tap_out_q;
  logic [L-1:0][TAP_BITS:0]     sum_w;
  logic                         done_q, fail_q;

  always_comb begin
    match      = '0;
    sum_w      = '0;
    center_val = '0;
    for (int l = 0; l < L; l++) begin
      match[l] = (rd_dq_i[8*l +: 8] == PAT_RISE) && (rd_dq_i[DATA_BITS + 8*l +: 8] == PAT_FALL);
      // Sum at TAP_BITS+1 bits so the midpoint of a window ending at max tap cannot wrap.
      sum_w[l]      = {1'b0, first_q[l]} + {1'b0, last_q[l]};
      center_val[l] = seen_q[l] ? sum_w[l][TAP_BITS:1] : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_i) state_d = LOAD0;
      LOAD0:  state_d = SETTLE;
      SETTLE: if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = REQ;
      REQ:    if (rd_ack_i) state_d = WAIT;
      WAIT: begin
        if (rd_valid_i) state_d = (smp_q == SMP_W'(SAMPLES - 1)) ? EVAL : REQ;
`ifdef SDDR_RDLVL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = FINISH;
`endif
      end
      EVAL:   state_d = (tap_q == '1) ? CENTER : STEP;
      STEP:   state_d = SETTLE;
      CENTER: state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_ddr_clock_i or posedge in_phy_reset_i) begin
    if (in_phy_reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      smp_q       <= '0;
      tap_q       <= '0;
      pass_q      <= '0;
      seen_q      <= '0;
      closed_q    <= '0;
      first_q     <= '0;
      last_q      <= '0;
      tap_out_q   <= '0;
      lane_fail_q <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (start_i) begin
          done_q      <= 1'b0;
          fail_q      <= 1'b0;
          lane_fail_q <= '0;
        end
        LOAD0: begin
          tap_q    <= '0;
          smp_q    <= '0;
          pass_q   <= '1;
          seen_q   <= '0;
          closed_q <= '0;
          first_q  <= '0;
          last_q   <= '0;
        end
        WAIT: begin
          if (rd_valid_i) begin
            pass_q <= pass_q & match;
            smp_q  <= smp_q + 1'b1;
          end
`ifdef SDDR_RDLVL_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            lane_fail_q <= '1;
            tap_out_q   <= '0;
          end
`endif
        end
        EVAL: for (int l = 0; l < L; l++) begin
          // Only the first window counts: once closed, later passes are ignored.
          if (pass_q[l]) begin
            if (!seen_q[l]) begin
              seen_q[l]  <= 1'b1;
              first_q[l] <= tap_q;
              last_q[l]  <= tap_q;
            end else if (!closed_q[l]) begin
              last_q[l] <= tap_q;
            end
          end else if (seen_q[l]) begin
            closed_q[l] <= 1'b1;
          end
        end
        STEP: begin
          tap_q  <= tap_q + 1'b1;
          smp_q  <= '0;
          pass_q <= '1;
        end
        CENTER: begin
          tap_out_q   <= center_val;
          lane_fail_q <= ~seen_q;
        end
        FINISH: begin
          done_q <= ~|lane_fail_q;
          fail_q <= |lane_fail_q;
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign rd_req_o    = (state_q == REQ);
  assign dly_ld_o    = (state_q == LOAD0 || state_q == CENTER) ? '1 : '0;
  assign dly_val_o   = (state_q == CENTER) ? center_val : '0;
  assign dly_ce_o    = (state_q == STEP) ? '1 : '0;
  assign dly_inc_o   = 1'b1;
  assign tap_o       = tap_out_q;
  assign lane_fail_o = lane_fail_q;
endmodule

// File: tb/tb_sddr_read_leveler.sv
// tb/tb_sddr_read_leveler.sv - directed bench for sddr_read_leveler with PHY/controller model.
module tb_sddr_read_leveler;
  localparam int DB = 16;
  localparam int TB = 5;
  localparam int L  = DB / 8;

  logic              in_ddr_clock_i = 1'b0;
  logic              in_phy_reset_i;
  logic              start_i;
  logic              busy_o, done_o, fail_o, rd_req_o;
  logic              rd_ack_i   = 1'b0;
  logic              rd_valid_i = 1'b0;
  logic [2*DB-1:0]   rd_dq_i    = '0;
  logic [L-1:0]      dly_ld_o, dly_ce_o, lane_fail_o;
  logic [L*TB-1:0]   dly_val_o, tap_o;
  logic              dly_inc_o;

  sddr_read_leveler dut (
    .in_ddr_clock_i (in_ddr_clock_i),
    .in_phy_reset_i (in_phy_reset_i),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .fail_o         (fail_o),
    .rd_req_o       (rd_req_o),
    .rd_ack_i       (rd_ack_i),
    .rd_valid_i     (rd_valid_i),
    .rd_dq_i        (rd_dq_i),
    .dly_ld_o       (dly_ld_o),
    .dly_val_o      (dly_val_o),
    .dly_ce_o       (dly_ce_o),
    .dly_inc_o      (dly_inc_o),
    .tap_o          (tap_o),
    .lane_fail_o    (lane_fail_o)
  );

  always #5 in_ddr_clock_i = ~in_ddr_clock_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pass_map [L];
  int          lane_tap [L];
  int          corrupt_lane = -1;
  int          corrupt_tap  = 0;
  int          corrupt_left = 0;
  int          pend = 0;
  bit          withhold = 1'b0;
  int          ld_cnt = 0, ce_cnt = 0, rd_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int a, input int b);
    logic [31:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Variable-delay elements: one tap per CE, LD takes the slice.
  initial begin
    for (int l = 0; l < L; l++) lane_tap[l] = 7;
  end
  always @(posedge in_ddr_clock_i) begin
    if (dly_ld_o[0]) ld_cnt++;
    if (dly_ce_o[0]) ce_cnt++;
    for (int l = 0; l < L; l++) begin
      if (dly_ld_o[l]) lane_tap[l] = int'(dly_val_o[l*TB +: TB]);
      else if (dly_ce_o[l]) lane_tap[l] = (lane_tap[l] + 1) % 32;
    end
  end

  // Controller/PHY: ack the request, return data three cycles later.
  always @(negedge in_ddr_clock_i) begin
    rd_ack_i   = 1'b0;
    rd_valid_i = 1'b0;
    rd_dq_i    = '0;
    if (in_phy_reset_i) begin
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0 && !withhold) begin
        rd_valid_i = 1'b1;
        rd_cnt++;
        for (int l = 0; l < L; l++) begin
          bit ok;
          ok = pass_map[l][lane_tap[l]];
          if (l == corrupt_lane && lane_tap[l] == corrupt_tap && corrupt_left > 0) begin
            if (corrupt_left == 1) ok = 1'b0;
            corrupt_left--;
          end
          if (ok) begin
            rd_dq_i[8*l +: 8]      = 8'h55;
            rd_dq_i[DB + 8*l +: 8] = 8'hAA;
          end else if (lane_tap[l] % 2 == 0) begin
            rd_dq_i[8*l +: 8]      = 8'h55;
            rd_dq_i[DB + 8*l +: 8] = 8'h2A;
          end else begin
            rd_dq_i[8*l +: 8]      = 8'h54;
            rd_dq_i[DB + 8*l +: 8] = 8'hAA;
          end
        end
      end
    end else if (rd_req_o) begin
      rd_ack_i = 1'b1;
      pend     = 3;
    end
  end

  task automatic run_cal(input bit mid_start);
    int n = 0;
    ld_cnt = 0; ce_cnt = 0; rd_cnt = 0;
    start_i = 1'b1;
    @(negedge in_ddr_clock_i);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    chk("status_cleared", {done_o, fail_o, lane_fail_o}, 0);
    while (!(done_o || fail_o) && n < 5000) begin
      start_i = mid_start && (n == 200);
      @(negedge in_ddr_clock_i);
      n++;
    end
    start_i = 1'b0;
    chk("cal_completes", n < 5000, 1);
    chk("busy_at_end", busy_o, 0);
  endtask

  task automatic check_result(input string tag, input logic [L*TB-1:0] tap_exp,
                              input logic [L-1:0] lf_exp, input int t0, input int t1);
    chk({tag, "_done"}, done_o, (lf_exp == 0));
    chk({tag, "_fail"}, fail_o, (lf_exp != 0));
    chk({tag, "_lane_fail"}, lane_fail_o, lf_exp);
    chk({tag, "_tap"}, tap_o, tap_exp);
    chk({tag, "_lane0_loaded"}, lane_tap[0], t0);
    chk({tag, "_lane1_loaded"}, lane_tap[1], t1);
    chk({tag, "_reads"}, rd_cnt, 128);
    chk({tag, "_ce_pulses"}, ce_cnt, 31);
    chk({tag, "_ld_pulses"}, ld_cnt, 2);
  endtask

  initial begin
    in_phy_reset_i = 1'b1;
    start_i        = 1'b0;
    repeat (3) @(negedge in_ddr_clock_i);
    chk("rst_flags", {busy_o, done_o, fail_o, rd_req_o}, 0);
    chk("rst_dly", {dly_ld_o, dly_ce_o, dly_val_o}, 0);
    chk("rst_inc", dly_inc_o, 1);
    chk("rst_outs", {tap_o, lane_fail_o}, 0);
    in_phy_reset_i = 1'b0;
    @(negedge in_ddr_clock_i);

    // Basic two-lane windows.
    pass_map[0] = rng(6, 14);
    pass_map[1] = rng(10, 20);
    run_cal(1'b0);
    check_result("t1", {5'd15, 5'd10}, 2'b00, 10, 15);
    repeat (2) @(negedge in_ddr_clock_i);
    chk("t1_done_level", {done_o, busy_o}, 2'b10);

    // Second window ignored; open window ending at max tap; start while busy ignored.
    pass_map[0] = rng(3, 5) | rng(9, 30);
    pass_map[1] = 32'hFFFF_FFFF;
    run_cal(1'b1);
    check_result("t2", {5'd15, 5'd4}, 2'b00, 4, 15);

    // Lane 1 never passes.
    pass_map[0] = rng(6, 14);
    pass_map[1] = 32'h0;
    run_cal(1'b0);
    check_result("t3", {5'd0, 5'd10}, 2'b10, 10, 0);

    // High window and one corrupted sample at tap 12 on lane 1.
    pass_map[0]  = rng(28, 31);
    pass_map[1]  = rng(8, 16);
    corrupt_lane = 1;
    corrupt_tap  = 12;
    corrupt_left = 3;
    run_cal(1'b0);
    check_result("t4", {5'd9, 5'd29}, 2'b00, 29, 9);
    corrupt_lane = -1;

    // Reset mid-sweep, then a clean full sweep.
    pass_map[0] = rng(6, 14);
    pass_map[1] = rng(10, 20);
    start_i = 1'b1;
    @(negedge in_ddr_clock_i);
    start_i = 1'b0;
    repeat (300) @(negedge in_ddr_clock_i);
    in_phy_reset_i = 1'b1;
    #1;
    chk("midrst_flags", {busy_o, done_o, fail_o, rd_req_o}, 0);
    chk("midrst_dly", {dly_ld_o, dly_ce_o, dly_val_o}, 0);
    chk("midrst_outs", {tap_o, lane_fail_o}, 0);
    @(negedge in_ddr_clock_i);
    in_phy_reset_i = 1'b0;
    @(negedge in_ddr_clock_i);
    run_cal(1'b0);
    check_result("t5", {5'd15, 5'd10}, 2'b00, 10, 15);

`ifdef SDDR_RDLVL_TIMEOUT_EN
    begin
      int n = 0;
      withhold = 1'b1;
      start_i = 1'b1;
      @(negedge in_ddr_clock_i);
      start_i = 1'b0;
      while (!(done_o || fail_o) && n < 500) begin
        @(negedge in_ddr_clock_i);
        n++;
      end
      chk("to_completes", n < 500, 1);
      chk("to_flags", {done_o, fail_o, busy_o}, 3'b010);
      chk("to_lane_fail", lane_fail_o, 2'b11);
      chk("to_tap", tap_o, 0);
      chk("to_min_wait", n >= 64, 1);
      withhold = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
